// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC vector sequencer slice.
package mac_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int VEC_LENGTH_DEF = 16;
  localparam int ACC_WIDTH_DEF  = DATA_WIDTH_DEF + 16;
  localparam int CNT_WIDTH_DEF  = 8;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic                     valid;
    logic                     first;
    logic                     last;
    logic [CNT_WIDTH_DEF-1:0] cnt;
  } seq_tag_t;

  // Chunk count for the next beat: restart at 1 on a first beat, saturate at all-ones.
  function automatic logic [CNT_WIDTH_DEF-1:0] cnt_step(input logic first,
                                                       input logic [CNT_WIDTH_DEF-1:0] prev);
    if (first)
      return CNT_WIDTH_DEF'(1);
    else if (&prev)
      return prev;
    else
      return prev + CNT_WIDTH_DEF'(1);
  endfunction

endpackage

// File: rtl/mac_seq_out_buf.sv
// One-entry valid/ready result buffer; a pop and a push may share a cycle.
module mac_seq_out_buf
  import mac_pkg::*;
#(
  parameter int RESULT_WIDTH = 2 * DATA_WIDTH_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [RESULT_WIDTH-1:0] push_result,
  input  logic [CNT_WIDTH-1:0]    push_chunks,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [RESULT_WIDTH-1:0] out_result,
  output logic [CNT_WIDTH-1:0]    out_chunks
);

  logic                    valid_reg;
  logic [RESULT_WIDTH-1:0] result_reg;
  logic [CNT_WIDTH-1:0]    chunks_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg  <= 1'b0;
      result_reg <= '0;
      chunks_reg <= '0;
    end else if (push) begin
      valid_reg  <= 1'b1;
      result_reg <= push_result;
      chunks_reg <= push_chunks;
    end else if (out_ready) begin
      valid_reg  <= 1'b0;
    end
  end

  assign out_valid  = valid_reg;
  assign out_result = result_reg;
  assign out_chunks = chunks_reg;

endmodule

// File: rtl/mac_vec_sequencer.sv
// Feeds framed activation/weight beats into the 2-stage parallel MAC and
// collects each finished dot product into a 1-entry output buffer.
module mac_vec_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int VEC_LENGTH   = VEC_LENGTH_DEF,
  parameter int ACC_WIDTH    = DATA_WIDTH + 16,
  parameter int RESULT_WIDTH = 2 * DATA_WIDTH,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_first,
  input  logic                             in_last,
  input  logic [DATA_WIDTH*VEC_LENGTH-1:0] in_act,
  input  logic [DATA_WIDTH*VEC_LENGTH-1:0] in_w,
  input  logic [ACC_WIDTH-1:0]             in_bias,
  output logic                             mac_en,
  output logic                             mac_load_accum,
  output logic [DATA_WIDTH*VEC_LENGTH-1:0] mac_act,
  output logic [DATA_WIDTH*VEC_LENGTH-1:0] mac_w,
  output logic [ACC_WIDTH-1:0]             mac_accum_prev,
  input  logic [RESULT_WIDTH-1:0]          mac_result,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [RESULT_WIDTH-1:0]          out_result,
  output logic [CNT_WIDTH-1:0]             out_chunks,
  output logic                             err
);

  localparam int VEC_BITS = DATA_WIDTH * VEC_LENGTH;

  seq_state_t            state_reg, state_next;
  seq_tag_t              tag0_reg, tag0_next, tag1_reg, tag2_reg;
  logic [VEC_BITS-1:0]   act_reg, act_next, w_reg, w_next;
  logic [ACC_WIDTH-1:0]  bias0_reg, bias0_next, bias1_reg;
  logic                  err_reg, err_next;
  logic                  stall, accept, keep_beat, push;

  assign stall    = out_valid && !out_ready;
  assign accept   = in_valid && !stall;
  assign in_ready = !stall;
  assign mac_en   = !stall;

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    bias0_next = bias0_reg;
    keep_beat  = 1'b0;
    tag0_next  = '{valid: 1'b0, first: 1'b0, last: 1'b0, cnt: tag0_reg.cnt};
    if (accept) begin
      unique case (state_reg)
        SEQ_IDLE: begin
          if (in_first) begin
            keep_beat  = 1'b1;
            state_next = in_last ? SEQ_IDLE : SEQ_RUN;
          end else begin
            err_next = 1'b1;
          end
        end
        SEQ_RUN: begin
          keep_beat = 1'b1;
          if (in_first) err_next = 1'b1;
          if (in_last) state_next = SEQ_IDLE;
        end
        default: state_next = SEQ_IDLE;
      endcase
    end
    if (keep_beat) begin
      tag0_next.valid = 1'b1;
      tag0_next.first = in_first;
      tag0_next.last  = in_last;
      tag0_next.cnt   = cnt_step(in_first, tag0_reg.cnt);
      if (in_first) bias0_next = in_bias;
    end
  end

  // Anything not kept becomes an all-zero bubble so the accumulator adds nothing.
  for (genvar gi = 0; gi < VEC_LENGTH; gi++) begin : g_lane
    assign act_next[gi*DATA_WIDTH +: DATA_WIDTH] = keep_beat ? in_act[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign w_next[gi*DATA_WIDTH +: DATA_WIDTH]   = keep_beat ? in_w[gi*DATA_WIDTH +: DATA_WIDTH]   : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= SEQ_IDLE;
      err_reg   <= 1'b0;
      tag0_reg  <= '0;
      tag1_reg  <= '0;
      tag2_reg  <= '0;
      act_reg   <= '0;
      w_reg     <= '0;
      bias0_reg <= '0;
      bias1_reg <= '0;
    end else if (!stall) begin
      state_reg <= state_next;
      err_reg   <= err_next;
      tag0_reg  <= tag0_next;
      act_reg   <= act_next;
      w_reg     <= w_next;
      bias0_reg <= bias0_next;
      tag1_reg  <= tag0_reg;
      bias1_reg <= bias0_reg;
      tag2_reg  <= tag1_reg;
    end
  end

  assign mac_act        = act_reg;
  assign mac_w          = w_reg;
  assign mac_load_accum = tag1_reg.valid && tag1_reg.first;
  assign mac_accum_prev = bias1_reg;
  assign err            = err_reg;
  assign push           = tag2_reg.valid && tag2_reg.last && !stall;

  mac_seq_out_buf #(
    .RESULT_WIDTH(RESULT_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_out_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_result(mac_result),
    .push_chunks(CNT_WIDTH'(tag2_reg.cnt)),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_chunks (out_chunks)
  );

endmodule

// File: tb/tb_mac_vec_sequencer.sv
// Directed bench for mac_vec_sequencer closed around a behavioural 2-stage MAC.
module tb_mac_vec_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic         in_ready;
  logic [127:0] in_act = '0, in_w = '0;
  logic [23:0]  in_bias = '0;
  logic         mac_en, mac_load_accum;
  logic [127:0] mac_act, mac_w;
  logic [23:0]  mac_accum_prev;
  logic [15:0]  mac_result;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [15:0]  out_result;
  logic [7:0]   out_chunks;
  logic         err;

  int n_vec = 0;
  int n_err = 0;
  int load_cnt = 0;

  typedef struct { logic [15:0] r; logic [7:0] c; } res_t;
  res_t res_q[$];

  typedef struct {
    int nbeats; int act; int w; int bias; int gap;
    logic [15:0] exp_result; int exp_chunks;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  mac_vec_sequencer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .in_act(in_act), .in_w(in_w), .in_bias(in_bias),
    .mac_en(mac_en), .mac_load_accum(mac_load_accum), .mac_act(mac_act), .mac_w(mac_w),
    .mac_accum_prev(mac_accum_prev), .mac_result(mac_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_chunks(out_chunks), .err(err)
  );

  // Behavioural MAC: psum register, then accumulator loaded or added.
  logic signed [23:0] lane_sum, psum, accum;
  logic signed [7:0]  lane_a, lane_b;
  logic signed [15:0] prod;
  always_comb begin
    lane_sum = '0;
    lane_a   = '0;
    lane_b   = '0;
    prod     = '0;
    for (int i = 0; i < 16; i++) begin
      lane_a   = mac_act[i*8 +: 8];
      lane_b   = mac_w[i*8 +: 8];
      prod     = lane_a * lane_b;
      lane_sum = lane_sum + {{8{prod[15]}}, prod};
    end
  end
  always @(posedge clk) begin
    if (reset) begin
      psum  <= '0;
      accum <= '0;
    end else if (mac_en) begin
      psum  <= lane_sum;
      accum <= mac_load_accum ? mac_accum_prev + psum : accum + psum;
    end
  end
  assign mac_result = accum[15:0];

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) res_q.push_back('{out_result, out_chunks});
    if (!reset && mac_load_accum && mac_en) load_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  task automatic send_beat(input logic f, input logic l, input int a, input int w, input int b);
    int budget = 200;
    in_valid = 1'b1; in_first = f; in_last = l;
    in_act = {16{8'(a)}}; in_w = {16{8'(w)}}; in_bias = 24'(b);
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      budget--;
      if (budget == 0) begin
        n_vec++; n_err++;
        $display("FAIL beat_accept: got in_ready=0 for 200 cycles expected acceptance");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_dot(input int n, input int a, input int w, input int b, input int gap);
    for (int i = 0; i < n; i++) begin
      send_beat(i == 0, i == n - 1, a, w, (i == 0) ? b : 0);
      if (gap > 0 && i < n - 1) begin
        repeat (gap) begin @(posedge clk); #1; end
        chk("bubble_zero_operands", 32'((mac_act == '0) && (mac_w == '0)), 32'd1);
      end
    end
  endtask

  task automatic wait_results(input int n);
    int b = 0;
    while (res_q.size() < n && b < 300) begin @(negedge clk); b++; end
    if (res_q.size() < n) begin
      n_vec++; n_err++;
      $display("FAIL wait_results: got %0d results expected %0d", res_q.size(), n);
    end
  endtask

  task automatic chk_res(input string name, input int idx, input logic [15:0] r, input int c);
    if (idx < res_q.size()) begin
      chk({name, "_result"}, 32'(res_q[idx].r), 32'(r));
      chk({name, "_chunks"}, 32'(res_q[idx].c), 32'(c));
    end
  endtask

  initial begin
    int lc0;
    bit stall_ok;
    int b;

    tbl[0] = '{4,  1,  1,  256, 0, 16'd320,  4};
    tbl[1] = '{4,  1,  1,  256, 2, 16'd320,  4};
    tbl[2] = '{2, -1,  3,   -5, 0, 16'hFF9B, 2};
    tbl[3] = '{3,  2,  3,   10, 1, 16'd298,  3};
    tbl[4] = '{1,  5, -4, 1000, 0, 16'd680,  1};

    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    chk("rst_out_valid",  32'(out_valid), 0);
    chk("rst_out_result", 32'(out_result), 0);
    chk("rst_out_chunks", 32'(out_chunks), 0);
    chk("rst_err",        32'(err), 0);
    chk("rst_mac_en",     32'(mac_en), 1);
    chk("rst_load_accum", 32'(mac_load_accum), 0);
    chk("rst_accum_prev", 32'(mac_accum_prev), 0);
    chk("rst_in_ready",   32'(in_ready), 1);

    // Single first&&last beat: latency and load_accum timing.
    res_q.delete();
    lc0 = load_cnt;
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
    in_act = {16{8'd1}}; in_w = {16{8'd2}}; in_bias = '0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    chk("single_e0_load", 32'(mac_load_accum), 0);
    @(posedge clk); #1;
    chk("single_e1_load", 32'(mac_load_accum), 1);
    chk("single_e1_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("single_e2_load", 32'(mac_load_accum), 0);
    chk("single_e2_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("single_e3_valid", 32'(out_valid), 1);
    chk("single_e3_result", 32'(out_result), 32);
    chk("single_e3_chunks", 32'(out_chunks), 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("single_load_pulses", 32'(load_cnt - lc0), 1);
    chk("single_result_count", 32'(res_q.size()), 1);

    // Table: back-to-back dot products, some with gaps between chunks.
    res_q.delete();
    lc0 = load_cnt;
    for (int i = 0; i < 5; i++)
      send_dot(tbl[i].nbeats, tbl[i].act, tbl[i].w, tbl[i].bias, tbl[i].gap);
    wait_results(5);
    for (int i = 0; i < 5; i++)
      chk_res($sformatf("tbl%0d", i), i, tbl[i].exp_result, tbl[i].exp_chunks);
    chk("tbl_load_pulses", 32'(load_cnt - lc0), 5);

    // Output stall while the next dot product streams in.
    res_q.delete();
    out_ready = 1'b0;
    stall_ok = 1'b1;
    fork
      begin
        send_dot(2, 1, 1, 0, 0);
        send_dot(6, 1, 2, 7, 0);
      end
      begin
        b = 0;
        while (!out_valid && b < 100) begin @(negedge clk); b++; end
        chk("stall_seen_valid", 32'(out_valid), 1);
        repeat (5) begin
          @(negedge clk);
          if (in_ready || mac_en) stall_ok = 1'b0;
        end
        chk("stall_ready_en_low", 32'(stall_ok), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_results(2);
    repeat (10) begin @(posedge clk); #1; end
    chk("stall_result_count", 32'(res_q.size()), 2);
    chk_res("stall_a", 0, 16'd32, 2);
    chk_res("stall_b", 1, 16'd199, 6);

    // Framing errors.
    pulse_reset();
    res_q.delete();
    send_beat(1'b0, 1'b1, 1, 1, 0);
    chk("idle_nonfirst_err", 32'(err), 1);
    repeat (8) begin @(posedge clk); #1; end
    chk("idle_nonfirst_dropped", 32'(res_q.size()), 0);
    pulse_reset();
    chk("reset_clears_err", 32'(err), 0);
    send_beat(1'b1, 1'b0, 1, 1, 0);
    send_beat(1'b1, 1'b0, 1, 3, 2);
    chk("run_first_err", 32'(err), 1);
    send_beat(1'b0, 1'b1, 1, 1, 0);
    wait_results(1);
    chk_res("restart", 0, 16'd66, 2);
    pulse_reset();
    chk("reset_clears_err2", 32'(err), 0);

    // Reset in the middle of a dot product.
    send_beat(1'b1, 1'b0, 3, 3, 50);
    send_beat(1'b0, 1'b0, 3, 3, 0);
    pulse_reset();
    res_q.delete();
    send_dot(2, 1, 1, 0, 0);
    wait_results(1);
    repeat (10) begin @(posedge clk); #1; end
    chk("midreset_result_count", 32'(res_q.size()), 1);
    chk_res("midreset", 0, 16'd32, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_vec_sequencer.md
Name: mac_vec_sequencer

Overview:
- Upstream feeder and result collector for the 16-lane parallel MAC unit (mac_unit_Parallel_128).
- Accepts a valid/ready stream of activation/weight vector beats, one beat per chunk of a dot product, with first/last framing and a per-dot-product bias.
- Registers the operands into the MAC and generates en, load_accum and accum_prev aligned to the MAC's 2-stage pipeline.
- Captures the MAC result into a 1-entry valid/ready output buffer.

Parameters:
- DATA_WIDTH, 8, operand width.
- VEC_LENGTH, 16, lanes per beat.
- ACC_WIDTH, DATA_WIDTH+16, MAC accumulator / bias width.
- RESULT_WIDTH, 2*DATA_WIDTH, MAC result width.
- CNT_WIDTH, 8, chunk-counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid&&in_ready.
- in_first  in  1  first chunk of a dot product.
- in_last  in  1  last chunk (first&&last allowed).
- in_act  in  DATA_WIDTH x VEC_LENGTH  signed activations.
- in_w  in  DATA_WIDTH x VEC_LENGTH  signed weights.
- in_bias  in  ACC_WIDTH  signed bias; sampled only on first beats.
- mac_en  out  1  to MAC en.
- mac_load_accum  out  1  to MAC load_accum.
- mac_act  out  DATA_WIDTH x VEC_LENGTH  to MAC act_in.
- mac_w  out  DATA_WIDTH x VEC_LENGTH  to MAC w_in.
- mac_accum_prev  out  ACC_WIDTH  to MAC accum_prev.
- mac_result  in  RESULT_WIDTH  from MAC result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_result  out  RESULT_WIDTH  captured result.
- out_chunks  out  CNT_WIDTH  beats in this dot product, saturating.
- err  out  1  sticky framing error.

Behaviour:
- stall = out_valid && !out_ready. mac_en = !stall. When stall is high, every sequencer register and the MAC hold their values.
- FSM has two states, IDLE and RUN. in_ready = !stall in both states.
  - IDLE: an accepted beat with first moves to RUN, or stays in IDLE if it also has last.
  - IDLE: an accepted beat without first is dropped (operands zeroed) and sets err.
  - RUN: an accepted beat with last returns to IDLE.
  - RUN: an accepted beat with first sets err, is treated as a new first (restarts the count, loads the bias) and stays in RUN.
- Stage 0 (operand regs, mac_act/mac_w, tags v0/f0/l0, bias0, cnt0) loads on every non-stalled edge.
  - With an accepted beat: loads the operands and tags.
  - Otherwise: loads zero operands with v0=0. Zero bubbles add 0 to the accumulator.
- Stage 1 tags (v1, f1, l1, bias1, cnt1) track the contents of the MAC psum register.
  - mac_load_accum = v1&&f1.
  - mac_accum_prev = bias1.
- Stage 2 tags (v2, l2, cnt2) track accum_out. When v2&&l2&&!stall, the buffer captures mac_result and cnt2, and out_valid rises.
- Output buffer is 1 entry:
  - Pop and push in the same cycle is allowed, giving bubble-free back-to-back results.
  - out_valid clears when out_ready is high and there is no push.
- Latency: a last beat accepted at edge E0 gives out_valid high after edge E3 (3 cycles), with no stalls.
- Chunk counter: cnt0 = 1 on a first beat, otherwise previous+1, saturating at 2^CNT_WIDTH-1.
- Bias: passed to the MAC unchanged (ACC_WIDTH, signed). There is no sequencer arithmetic beyond the counter.
- Reset values:
  - state=IDLE, all tags 0, operand regs 0, bias 0.
  - out_valid=0, out_result=0, out_chunks=0, err=0.
  - mac_en=1, mac_load_accum=0, mac_accum_prev=0.
- Reset mid-operation discards in-flight beats and clears err. The MAC shares the reset.
- Back-to-back dot products: a first beat may immediately follow a last beat. Bias is loaded exactly when the new first beat's psum reaches accum_out.

Decomposition:
- Shared package mac_pkg holds:
  - default DATA_WIDTH/VEC_LENGTH/ACC_WIDTH constants;
  - the FSM state enum (SEQ_IDLE, SEQ_RUN);
  - a tag struct {valid, first, last, cnt}.
- One natural sub-module: mac_seq_out_buf (1-entry valid/ready result buffer).
- The MAC is instantiated by the parent, not inside this block.

Test Plan:
- Single beat (first&&last): all act=1, w=2, bias=0 → MAC accumulates 32; out_valid 3 cycles after acceptance; out_chunks=1; mac_load_accum high exactly 1 cycle, one cycle after acceptance.
- 4-beat dot product: act=1, w=1, bias=0x000100 → accumulator 64+256=320; out_chunks=4; mac_load_accum high only for chunk 0.
- in_valid gaps between chunks (2 idle cycles) → identical result to the gapless case; zero bubbles confirmed at mac_act.
- out_ready low for 5 cycles while the next dot product is streaming → in_ready=0 and mac_en=0 during the stall; no result lost or duplicated; both results delivered in order.
- Framing errors: non-first beat in IDLE → dropped, err=1. First beat inside RUN → err=1 and the restarted dot product's result is correct. reset → err=0.
- Reset asserted mid-dot-product, then a fresh 2-beat product → only the fresh result appears; out_chunks=2.
